// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: exception/xRET requests in, CSR write strobes and fetch redirect out.
// Handshake: a request (exception or mret/sret_commit) is accepted only while busy=0; the upstream holds while busy=1.
interface trap_sequencer_if #(parameter int XLEN = 32);
  logic            exception;
  logic [4:0]      exception_code;
  logic [XLEN-1:0] exception_pc;
  logic [XLEN-1:0] exception_val;
  logic            mret_commit;
  logic            sret_commit;
  logic [XLEN-1:0] medeleg;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] stvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] sepc;
  logic [1:0]      priv_o;
  logic            busy;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            csr_trap_we;
  logic            csr_trap_s;
  logic [XLEN-1:0] csr_epc;
  logic [XLEN-1:0] csr_tval;
  logic [XLEN-1:0] csr_cause;
  logic            mstatus_we;
  logic [XLEN-1:0] mstatus_o;

  modport master (
    output exception, exception_code, exception_pc, exception_val,
    output mret_commit, sret_commit, medeleg, mstatus_i, mtvec, stvec, mepc, sepc,
    input  priv_o, busy, flush, redirect_valid, redirect_pc, csr_trap_we, csr_trap_s,
    input  csr_epc, csr_tval, csr_cause, mstatus_we, mstatus_o
  );

  modport slave (
    input  exception, exception_code, exception_pc, exception_val,
    input  mret_commit, sret_commit, medeleg, mstatus_i, mtvec, stvec, mepc, sepc,
    output priv_o, busy, flush, redirect_valid, redirect_pc, csr_trap_we, csr_trap_s,
    output csr_epc, csr_tval, csr_cause, mstatus_we, mstatus_o
  );
endinterface

// File: rtl/trap_sequencer.sv
// Sequences trap entry and xRET: resolves M/S delegation, emits CSR/mstatus writes,
// owns the privilege register and flushes/redirects fetch.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  trap_sequencer_if.slave       bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_TRAP_COMMIT = 2'd1,
    S_RET_COMMIT  = 2'd2,
    S_REDIRECT    = 2'd3
  } state_e;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  state_e          state_q, state_d;
  logic [1:0]      priv_q, priv_d;
  logic [4:0]      code_q;
  logic [XLEN-1:0] pc_q, val_q;
  logic            to_s_q, mret_q;
  logic [XLEN-1:0] target_q, target_d;
  logic            latch_exc, latch_ret;

  logic [1:0]      mpp_eff;
  logic [XLEN-1:0] trap_mstatus, ret_mstatus;
  logic [1:0]      ret_priv;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      priv_q   <= PRIV_M;
      code_q   <= '0;
      pc_q     <= '0;
      val_q    <= '0;
      to_s_q   <= 1'b0;
      mret_q   <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      priv_q   <= priv_d;
      target_q <= target_d;
      if (latch_exc) begin
        code_q <= bus.exception_code;
        pc_q   <= bus.exception_pc;
        val_q  <= bus.exception_val;
        to_s_q <= (priv_q != PRIV_M) && bus.medeleg[bus.exception_code];
      end
      if (latch_ret) begin
        mret_q <= bus.mret_commit;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    latch_exc = 1'b0;
    latch_ret = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.exception) begin
          state_d   = S_TRAP_COMMIT;
          latch_exc = 1'b1;
        end else if (bus.mret_commit || bus.sret_commit) begin
          state_d   = S_RET_COMMIT;
          latch_ret = 1'b1;
        end
      end
      S_TRAP_COMMIT: state_d = S_REDIRECT;
      S_RET_COMMIT:  state_d = S_REDIRECT;
      default:       state_d = S_IDLE;
    endcase
  end

  // New mstatus / privilege for trap entry and xRET; reserved MPP=10 returns to U
  always_comb begin
    mpp_eff      = (bus.mstatus_i[12:11] == 2'b10) ? PRIV_U : bus.mstatus_i[12:11];
    trap_mstatus = bus.mstatus_i;
    ret_mstatus  = bus.mstatus_i;
    ret_priv     = PRIV_U;
    if (to_s_q) begin
      trap_mstatus[5] = bus.mstatus_i[1];
      trap_mstatus[1] = 1'b0;
      trap_mstatus[8] = priv_q[0];
    end else begin
      trap_mstatus[7]     = bus.mstatus_i[3];
      trap_mstatus[3]     = 1'b0;
      trap_mstatus[12:11] = priv_q;
    end
    if (mret_q) begin
      ret_priv           = mpp_eff;
      ret_mstatus[3]     = bus.mstatus_i[7];
      ret_mstatus[7]     = 1'b1;
      ret_mstatus[12:11] = PRIV_U;
      if (mpp_eff != PRIV_M) ret_mstatus[17] = 1'b0;
    end else begin
      ret_priv        = {1'b0, bus.mstatus_i[8]};
      ret_mstatus[1]  = bus.mstatus_i[5];
      ret_mstatus[5]  = 1'b1;
      ret_mstatus[8]  = 1'b0;
      ret_mstatus[17] = 1'b0;
    end
  end

  always_comb begin
    priv_d   = priv_q;
    target_d = target_q;
    case (state_q)
      S_TRAP_COMMIT: begin
        priv_d   = to_s_q ? PRIV_S : PRIV_M;
        target_d = (to_s_q ? bus.stvec : bus.mtvec) & ~XLEN'(3);
      end
      S_RET_COMMIT: begin
        priv_d   = ret_priv;
        target_d = (mret_q ? bus.mepc : bus.sepc) & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  // Outputs; forced quiet while reset_n is low so an aborted sequence emits nothing
  always_comb begin
    bus.priv_o         = reset_n ? priv_q : PRIV_M;
    bus.busy           = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.csr_trap_we    = 1'b0;
    bus.csr_trap_s     = 1'b0;
    bus.csr_epc        = '0;
    bus.csr_tval       = '0;
    bus.csr_cause      = '0;
    bus.mstatus_we     = 1'b0;
    bus.mstatus_o      = '0;
    dbg_state_o        = reset_n ? state_q : S_IDLE;
    if (reset_n) begin
      bus.busy = (state_q != S_IDLE);
      case (state_q)
        S_TRAP_COMMIT: begin
          bus.flush       = 1'b1;
          bus.csr_trap_we = 1'b1;
          bus.csr_trap_s  = to_s_q;
          bus.csr_epc     = pc_q;
          bus.csr_tval    = val_q;
          bus.csr_cause   = {{(XLEN-5){1'b0}}, code_q};
          bus.mstatus_we  = 1'b1;
          bus.mstatus_o   = trap_mstatus;
        end
        S_RET_COMMIT: begin
          bus.flush      = 1'b1;
          bus.mstatus_we = 1'b1;
          bus.mstatus_o  = ret_mstatus;
        end
        S_REDIRECT: begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = target_q;
        end
        default: ;
      endcase
    end
  end

endmodule
